// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the parametrised dual-port RAM.
//   ram_state_t : controller state (SWEEP = clearing memory, RUN = serving ports)
//   ram_rsel_t  : source selected for the read data of the last completed read
//   OUT_REG_*   : values for the OUT_REG parameter (read latency 1 or 2)
//   BYPASS_*    : values for the BYPASS parameter (same-address read-during-write)
package ram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    // Where the first-stage read data comes from.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,   // after clear, or an out-of-range read
        SEL_CORE = 2'd1,   // array contents
        SEL_BYP  = 2'd2    // write data forwarded on a same-address collision
    } ram_rsel_t;

    localparam int OUT_REG_OFF = 0;
    localparam int OUT_REG_ON  = 1;
    localparam int BYPASS_OLD  = 0;
    localparam int BYPASS_NEW  = 1;

endpackage

// File: rtl/ram_dp_core.sv
// ram_dp_core: bare WIDTH x DEPTH storage array with one synchronous write port
// and one synchronous read port. No reset so it maps onto block RAM.
// A same-address read and write on the same edge returns the old contents.
//   i_clk   : clock
//   i_we    : write enable;  i_waddr / i_wdata : write address / data
//   i_re    : read enable;   i_raddr : read address
//   o_rdata : registered read data, holds while i_re is low
module ram_dp_core #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Callers only present in-range addresses when the enables are high.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_dp_sync_param.sv
// ram_dp_sync_param: single-clock simple dual-port RAM with a hardware clear
// sweep, registered read path with a valid pulse, optional extra output stage
// and selectable read-during-write behaviour.
//   clk      : sole clock
//   clr      : synchronous active-high reset, (re)starts the clear sweep
//   we / wr_addr / data_in : write port
//   re / rd_addr           : read port
//   data_out : read data (latency 1 + OUT_REG), holds between reads
//   rd_valid : one-cycle pulse per completed read
//   busy     : high while the clear sweep runs; port requests are ignored
module ram_dp_sync_param
    import ram_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OUT_REG = OUT_REG_OFF,
    parameter int BYPASS  = BYPASS_NEW
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int                LAT     = 1 + OUT_REG;
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    // ---------------------------------------------------------------
    // Controller: clear sweep then run
    // ---------------------------------------------------------------
    ram_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              w_sweep_we;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sweep_we  = 1'b0;
        case (r_state)
            SWEEP: begin
                // clr held high keeps the sweep parked at address 0 without writing
                w_sweep_we = !clr;
                w_ptr_nxt  = r_ptr + 1'b1;
                if (r_ptr == LAST) begin
                    w_state_nxt = RUN;
                    w_ptr_nxt   = '0;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = SWEEP;
            end
        endcase
    end

    assign busy = (r_state == SWEEP);

    // ---------------------------------------------------------------
    // Request qualification
    // ---------------------------------------------------------------
    logic w_run, w_wr_in, w_rd_in, w_wr_ok, w_rd_acc, w_hit;

    assign w_run    = !busy && !clr;
    assign w_wr_in  = ({1'b0, wr_addr} < DEPTH_X);
    assign w_rd_in  = ({1'b0, rd_addr} < DEPTH_X);
    assign w_wr_ok  = w_run && we && w_wr_in;
    assign w_rd_acc = w_run && re;
    // Collision forwarding only exists in new-data mode; the core itself
    // returns old data on a same-address access.
    assign w_hit    = (BYPASS == BYPASS_NEW) && w_wr_ok && w_rd_acc && w_rd_in
                      && (wr_addr == rd_addr);

    // ---------------------------------------------------------------
    // Storage: write port shared between the sweep and the user
    // ---------------------------------------------------------------
    logic              w_c_we, w_c_re;
    logic [ADDR_W-1:0] w_c_waddr;
    logic [WIDTH-1:0]  w_c_wdata, w_c_rdata;

    assign w_c_we    = w_sweep_we || w_wr_ok;
    assign w_c_waddr = busy ? r_ptr : wr_addr;
    assign w_c_wdata = busy ? '0 : data_in;
    assign w_c_re    = w_rd_acc && w_rd_in;

    ram_dp_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk   (clk),
        .i_we    (w_c_we),
        .i_waddr (w_c_waddr),
        .i_wdata (w_c_wdata),
        .i_re    (w_c_re),
        .i_raddr (rd_addr),
        .o_rdata (w_c_rdata)
    );

    // ---------------------------------------------------------------
    // Read pipeline
    // ---------------------------------------------------------------
    logic [LAT:1]     r_vld_pipe;
    ram_rsel_t        r_sel;
    logic [WIDTH-1:0] r_byp_data;
    logic [WIDTH-1:0] w_s1_data;

    // Source select and forwarded data only change on an accepted read, so the
    // first-stage data holds between reads exactly like the core output does.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_vld_pipe <= '0;
            r_sel      <= SEL_ZERO;
            r_byp_data <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_acc;
            for (int i = 2; i <= LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
            if (w_rd_acc) begin
                if (!w_rd_in) begin
                    r_sel <= SEL_ZERO;
                end else if (w_hit) begin
                    r_sel <= SEL_BYP;
                end else begin
                    r_sel <= SEL_CORE;
                end
            end
            if (w_hit) begin
                r_byp_data <= data_in;
            end
        end
    end

    always_comb begin
        w_s1_data = '0;
        case (r_sel)
            SEL_CORE: w_s1_data = w_c_rdata;
            SEL_BYP:  w_s1_data = r_byp_data;
            default:  w_s1_data = '0;
        endcase
    end

    generate
        if (OUT_REG == OUT_REG_ON) begin : g_out_reg
            logic [WIDTH-1:0] r_dout;

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_dout <= '0;
                end else if (r_vld_pipe[1]) begin
                    r_dout <= w_s1_data;
                end
            end

            assign data_out = r_dout;
        end else begin : g_out_direct
            // First-stage data is already a registered read result.
            assign data_out = w_s1_data;
        end
    endgenerate

    assign rd_valid = r_vld_pipe[LAT];

endmodule
